wav_fetch: RTL and testbench

Byte prefetch stage between the DDRAM byte port and the wave player. On a start pulse it streams a byte range (base, length) out of DDRAM, one outstanding read at a time, into a small show-ahead FIFO. The wave player pops bytes from that FIFO at its own pace. The stage optionally loops the range and hides DDRAM latency from the player.

---
 rtl/wav_pkg.sv | 20 ++
 rtl/wav_fifo.sv | 67 ++++++
 rtl/wav_fetch.sv | 147 ++++++++++++++
 tb/tb_wav_fetch.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wav_pkg.sv
// wav_pkg: shared types and sizing for the wave fetch path.
//   wav_state_e    : fetch FSM states
//   WAV_AW         : DDRAM byte address / length width
//   WAV_FIFO_DEPTH : prefetch FIFO entries (power of two, >= 4)
package wav_pkg;

    localparam int WAV_AW         = 28;
    localparam int WAV_FIFO_DEPTH = 16;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        GUARD,
        WAIT,
        HOLD,
        DRAIN,
        STOP
    } wav_state_e;

endpackage

// File: rtl/wav_fifo.sv
// wav_fifo: synchronous show-ahead FIFO with flush.
//   clk_sys, rst : clock, asynchronous active-high reset
//   flush        : empties the FIFO; wins over push/pop in the same cycle
//   push, din    : write din when not full (or when a pop frees a slot)
//   pop          : drop the head; ignored when empty
//   dout         : head entry, reads as 0 when empty
//   valid, level : not-empty flag and occupancy
module wav_fifo #(
    parameter int DEPTH = 16,
    parameter int DW    = 8
) (
    input  logic                       clk_sys,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DW-1:0]              din,
    output logic [DW-1:0]              dout,
    output logic                       valid,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [LW-1:0] cnt;
    logic          do_pop;
    logic          do_push;

    assign do_pop  = pop && (cnt != '0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && ((cnt != LVL_FULL) || do_pop);

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + LW'(1);
                2'b01:   cnt <= cnt - LW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset: dout is masked while the FIFO is empty.
    always_ff @(posedge clk_sys) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

    assign valid = (cnt != '0);
    assign dout  = valid ? mem[rd_ptr] : '0;
    assign level = cnt;

endmodule

// File: rtl/wav_fetch.sv
// wav_fetch: streams a DDRAM byte range into a show-ahead FIFO for the
// wave player, one outstanding read at a time, with optional looping.
//   I_CLK, I_RST                 : clk_sys and asynchronous active-high reset
//   I_START, I_BASE_ADDR,
//   I_LENGTH, I_LOOP             : range control (start pulse latches, flushes)
//   O_MEM_ADDR, O_MEM_RD,
//   I_MEM_DATA, I_MEM_READY      : DDRAM byte port
//   O_DATA, O_VALID, I_POP,
//   O_LEVEL                      : player side of the FIFO
//   O_DONE                       : non-loop range fetched and FIFO drained
module wav_fetch
    import wav_pkg::*;
#(
    parameter int DEPTH = WAV_FIFO_DEPTH,
    parameter int AW    = WAV_AW
) (
    input  logic                   I_CLK,
    input  logic                   I_RST,
    input  logic                   I_START,
    input  logic [AW-1:0]          I_BASE_ADDR,
    input  logic [AW-1:0]          I_LENGTH,
    input  logic                   I_LOOP,
    output logic [AW-1:0]          O_MEM_ADDR,
    output logic                   O_MEM_RD,
    input  logic [7:0]             I_MEM_DATA,
    input  logic                   I_MEM_READY,
    output logic [7:0]             O_DATA,
    output logic                   O_VALID,
    input  logic                   I_POP,
    output logic [$clog2(DEPTH):0] O_LEVEL,
    output logic                   O_DONE
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] LVL_FULL    = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_FULL_M1 = LW'(DEPTH - 1);

    wav_state_e    state, state_nxt;
    logic [AW-1:0] addr_q, addr_nxt;
    logic [AW-1:0] rem_q,  rem_nxt;
    logic [AW-1:0] base_q, base_nxt;
    logic [AW-1:0] len_q,  len_nxt;
    logic          fifo_push;
    logic          fifo_flush;
    logic          pop_eff;
    logic [LW-1:0] level;
    logic [LW-1:0] level_net;   // level once this cycle's pop has landed

    assign pop_eff   = I_POP && (level != '0);
    assign level_net = level - LW'(pop_eff);

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            state  <= IDLE;
            addr_q <= '0;
            rem_q  <= '0;
            base_q <= '0;
            len_q  <= '0;
        end else begin
            state  <= state_nxt;
            addr_q <= addr_nxt;
            rem_q  <= rem_nxt;
            base_q <= base_nxt;
            len_q  <= len_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        addr_nxt   = addr_q;
        rem_nxt    = rem_q;
        base_nxt   = base_q;
        len_nxt    = len_q;
        fifo_push  = 1'b0;
        fifo_flush = 1'b0;

        if (I_START) begin
            fifo_flush = 1'b1;
            base_nxt   = I_BASE_ADDR;
            len_nxt    = I_LENGTH;
            addr_nxt   = I_BASE_ADDR;
            rem_nxt    = I_LENGTH;
            // A read already accepted by DDRAM must be drained before the
            // next request; an ISSUE-cycle request is simply re-issued.
            if (state == GUARD || state == WAIT || state == DRAIN)
                state_nxt = DRAIN;
            else
                state_nxt = (I_LENGTH != '0) ? ISSUE : STOP;
        end else begin
            case (state)
                IDLE:  state_nxt = IDLE;
                ISSUE: state_nxt = GUARD;
                // READY may still be high from the previous transfer here.
                GUARD: state_nxt = WAIT;
                WAIT: begin
                    if (I_MEM_READY) begin
                        fifo_push = 1'b1;
                        if (rem_q == AW'(1) && !I_LOOP) begin
                            addr_nxt  = addr_q + AW'(1);
                            rem_nxt   = '0;
                            state_nxt = STOP;
                        end else begin
                            if (rem_q == AW'(1)) begin
                                addr_nxt = base_q;
                                rem_nxt  = len_q;
                            end else begin
                                addr_nxt = addr_q + AW'(1);
                                rem_nxt  = rem_q - AW'(1);
                            end
                            // After this push the FIFO must still have a slot.
                            state_nxt = (level_net < LVL_FULL_M1) ? ISSUE : HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (level_net < LVL_FULL && rem_q != '0) state_nxt = ISSUE;
                end
                DRAIN: begin
                    if (I_MEM_READY) state_nxt = (rem_q != '0) ? ISSUE : STOP;
                end
                STOP:    state_nxt = STOP;
                default: state_nxt = IDLE;
            endcase
        end
    end

    wav_fifo #(
        .DEPTH (DEPTH),
        .DW    (8)
    ) u_fifo (
        .clk_sys (I_CLK),
        .rst     (I_RST),
        .flush   (fifo_flush),
        .push    (fifo_push),
        .pop     (I_POP),
        .din     (I_MEM_DATA),
        .dout    (O_DATA),
        .valid   (O_VALID),
        .level   (level)
    );

    assign O_MEM_ADDR = addr_q;
    assign O_MEM_RD   = (state == ISSUE);
    assign O_LEVEL    = level;
    assign O_DONE     = (state == STOP) && (level == '0);

endmodule

// File: tb/tb_wav_fetch.sv
module tb_wav_fetch;

    localparam int DEPTH = 16;
    localparam int AW    = 28;
    localparam int LW    = 5;

    logic          I_CLK = 1'b0;
    logic          I_RST;
    logic          I_START;
    logic [AW-1:0] I_BASE_ADDR;
    logic [AW-1:0] I_LENGTH;
    logic          I_LOOP;
    logic [AW-1:0] O_MEM_ADDR;
    logic          O_MEM_RD;
    logic [7:0]    I_MEM_DATA  = 8'h00;
    logic          I_MEM_READY = 1'b1;
    logic [7:0]    O_DATA;
    logic          O_VALID;
    logic          I_POP;
    logic [LW-1:0] O_LEVEL;
    logic          O_DONE;

    always #5 I_CLK = ~I_CLK;

    wav_fetch #(.DEPTH(DEPTH), .AW(AW)) dut (
        .I_CLK       (I_CLK),
        .I_RST       (I_RST),
        .I_START     (I_START),
        .I_BASE_ADDR (I_BASE_ADDR),
        .I_LENGTH    (I_LENGTH),
        .I_LOOP      (I_LOOP),
        .O_MEM_ADDR  (O_MEM_ADDR),
        .O_MEM_RD    (O_MEM_RD),
        .I_MEM_DATA  (I_MEM_DATA),
        .I_MEM_READY (I_MEM_READY),
        .O_DATA      (O_DATA),
        .O_VALID     (O_VALID),
        .I_POP       (I_POP),
        .O_LEVEL     (O_LEVEL),
        .O_DONE      (O_DONE)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // DDRAM byte port: byte at address a is a[7:0]; READY drops on a request
    // and returns lat-1 cycles later together with the data.
    int            lat_min = 2;
    int            lat_max = 2;
    bit            mem_busy = 1'b0;
    int            mem_cnt  = 0;
    logic [AW-1:0] mem_a    = '0;

    always begin
        @(posedge I_CLK);
        #1;
        if (O_MEM_RD) begin
            mem_busy    = 1'b1;
            mem_a       = O_MEM_ADDR;
            mem_cnt     = int'($urandom_range(lat_max, lat_min)) - 1;
            I_MEM_READY = 1'b0;
        end else if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt <= 0) begin
                mem_busy    = 1'b0;
                I_MEM_READY = 1'b1;
                I_MEM_DATA  = mem_a[7:0];
            end
        end
    end

    // Transaction-level reference: FIFO contents as a queue, the expected
    // address/remaining sequence, and the one outstanding read.
    logic [7:0]    mq[$];
    logic [AW-1:0] m_addr = '0, m_rem = '0, m_base = '0, m_len = '0;
    bit            m_stop = 1'b0, m_pend_stop = 1'b0;
    bit            o_valid = 1'b0, o_abort = 1'b0;
    logic [AW-1:0] o_addr = '0;
    int            o_cyc = 0;
    int            cyc = 0;
    int            rd_total = 0;
    bit            chk_en = 1'b0;

    always @(negedge I_CLK) begin : model
        bit cap;
        cyc++;
        if (I_RST) begin
            mq.delete();
            m_addr = '0; m_rem = '0; m_base = '0; m_len = '0;
            m_stop = 1'b0; m_pend_stop = 1'b0;
            o_valid = 1'b0; o_abort = 1'b0;
        end else if (chk_en) begin
            chk("level", O_LEVEL, mq.size());
            chk("valid", O_VALID, mq.size() != 0);
            chk("data", O_DATA, (mq.size() == 0) ? 8'h00 : mq[0]);
            chk("done", O_DONE, m_stop && mq.size() == 0);
            if (O_MEM_RD) begin
                rd_total++;
                chk("rd_addr", O_MEM_ADDR, m_addr);
                chk("rd_legal", mq.size() < DEPTH && m_rem != 0 && !m_stop && !o_abort, 1);
                o_valid = 1'b1;
                o_abort = 1'b0;
                o_addr  = O_MEM_ADDR;
                o_cyc   = cyc;
            end else if (o_valid && !o_abort) begin
                chk("addr_stable", O_MEM_ADDR, o_addr);
            end
            cap = o_valid && I_MEM_READY && (cyc >= o_cyc + 2);
            if (I_START) begin
                mq.delete();
                m_base = I_BASE_ADDR; m_len = I_LENGTH;
                m_addr = I_BASE_ADDR; m_rem = I_LENGTH;
                if (o_valid && o_cyc < cyc) begin
                    o_abort     = 1'b1;
                    m_stop      = 1'b0;
                    m_pend_stop = (I_LENGTH == '0);
                end else begin
                    o_valid     = 1'b0;
                    o_abort     = 1'b0;
                    m_stop      = (I_LENGTH == '0);
                    m_pend_stop = 1'b0;
                end
            end else begin
                if (I_POP && mq.size() > 0) void'(mq.pop_front());
                if (cap) begin
                    o_valid = 1'b0;
                    if (o_abort) begin
                        o_abort = 1'b0;
                        if (m_pend_stop) begin
                            m_stop      = 1'b1;
                            m_pend_stop = 1'b0;
                        end
                    end else begin
                        mq.push_back(o_addr[7:0]);
                        m_addr = m_addr + 1'b1;
                        m_rem  = m_rem - 1'b1;
                        if (m_rem == '0) begin
                            if (I_LOOP) begin
                                m_addr = m_base;
                                m_rem  = m_len;
                            end else begin
                                m_stop = 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge I_CLK);
            #1;
        end
    endtask

    task automatic do_start(input logic [AW-1:0] base, input logic [AW-1:0] len, input logic loop);
        I_BASE_ADDR = base;
        I_LENGTH    = len;
        I_LOOP      = loop;
        I_START     = 1'b1;
        tick();
        I_START     = 1'b0;
    endtask

    task automatic wait_level(input int lvl, input int bound, input string name);
        for (int i = 0; i < bound && int'(O_LEVEL) != lvl; i++) tick();
        chk(name, O_LEVEL, lvl);
    endtask

    task automatic wait_rd(input int bound, input string name);
        for (int i = 0; i < bound && !O_MEM_RD; i++) tick();
        chk(name, O_MEM_RD, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int got;
        int pop_pct;
        I_RST = 1'b1; I_START = 1'b0; I_BASE_ADDR = '0; I_LENGTH = '0;
        I_LOOP = 1'b0; I_POP = 1'b0;
        tick(3);
        chk("rst_addr",  O_MEM_ADDR, 0);
        chk("rst_rd",    O_MEM_RD, 0);
        chk("rst_data",  O_DATA, 0);
        chk("rst_valid", O_VALID, 0);
        chk("rst_level", O_LEVEL, 0);
        chk("rst_done",  O_DONE, 0);
        I_RST  = 1'b0;
        chk_en = 1'b1;
        tick(2);

        // Basic fetch with minimum latency.
        r0 = rd_total;
        do_start(28'h100, 28'd4, 1'b0);
        chk("t1_rd_c1", O_MEM_RD, 1);
        chk("t1_addr_c1", O_MEM_ADDR, 28'h100);
        tick(2);
        chk("t1_valid_c3", O_VALID, 0);
        tick();
        chk("t1_valid_c4", O_VALID, 1);
        chk("t1_data_c4", O_DATA, 8'h00);
        wait_level(4, 60, "t1_fill");
        I_POP = 1'b1;
        chk("t1_byte0", O_DATA, 8'h00); tick();
        chk("t1_byte1", O_DATA, 8'h01); tick();
        chk("t1_byte2", O_DATA, 8'h02); tick();
        chk("t1_byte3", O_DATA, 8'h03); tick();
        I_POP = 1'b0;
        chk("t1_done", O_DONE, 1);
        chk("t1_empty", O_VALID, 0);
        chk("t1_rd_count", rd_total - r0, 4);

        // Zero length.
        r0 = rd_total;
        do_start(28'h500, 28'd0, 1'b0);
        chk("t4_done_c1", O_DONE, 1);
        chk("t4_no_rd", O_MEM_RD, 0);
        tick(5);
        chk("t4_rd_count", rd_total - r0, 0);
        chk("t4_done_hold", O_DONE, 1);

        // Backpressure: FIFO fills, one pop buys one more read.
        r0 = rd_total;
        do_start(28'h1000, 28'd40, 1'b0);
        wait_level(16, 300, "t2_fill");
        tick(10);
        chk("t2_rd16", rd_total - r0, 16);
        chk("t2_level16", O_LEVEL, 16);
        chk("t2_no_rd_full", O_MEM_RD, 0);
        I_POP = 1'b1;
        tick();
        I_POP = 1'b0;
        chk("t2_level15", O_LEVEL, 15);
        chk("t2_rd_after_pop", O_MEM_RD, 1);
        tick(20);
        chk("t2_rd17", rd_total - r0, 17);
        chk("t2_refill", O_LEVEL, 16);

        // Loop with continuous pops.
        do_start(28'h10, 28'd3, 1'b1);
        I_POP = 1'b1;
        got = 0;
        for (int i = 0; i < 300 && got < 9; i++) begin
            if (O_VALID) begin
                chk("t3_byte", O_DATA, 8'h10 + 8'(got % 3));
                got++;
            end
            chk("t3_not_done", O_DONE, 0);
            tick();
        end
        chk("t3_count", got, 9);
        I_POP = 1'b0;

        // Restart while a read to 0x105 is pending.
        lat_min = 8; lat_max = 8;
        do_start(28'h100, 28'd10, 1'b0);
        for (int i = 0; i < 400 && !(O_MEM_RD && O_MEM_ADDR == 28'h105); i++) tick();
        chk("t5_saw_105", O_MEM_ADDR, 28'h105);
        tick(2);
        do_start(28'h200, 28'd4, 1'b0);
        chk("t5_flushed", O_LEVEL, 0);
        chk("t5_flushed_valid", O_VALID, 0);
        wait_rd(50, "t5_next_rd");
        chk("t5_next_addr", O_MEM_ADDR, 28'h200);
        for (int i = 0; i < 50 && !O_VALID; i++) tick();
        chk("t5_first_valid", O_VALID, 1);
        chk("t5_first_byte", O_DATA, 8'h00);
        chk("t5_one_byte", O_LEVEL, 1);

        // Async reset while in GUARD.
        lat_min = 4; lat_max = 4;
        wait_rd(60, "t6_rd");
        tick();
        #2;
        I_RST = 1'b1;
        #1;
        chk("t6_rst_addr",  O_MEM_ADDR, 0);
        chk("t6_rst_rd",    O_MEM_RD, 0);
        chk("t6_rst_data",  O_DATA, 0);
        chk("t6_rst_valid", O_VALID, 0);
        chk("t6_rst_level", O_LEVEL, 0);
        chk("t6_rst_done",  O_DONE, 0);
        tick();
        I_RST = 1'b0;
        r0 = rd_total;
        tick(10);
        chk("t6_late_ready_level", O_LEVEL, 0);
        chk("t6_no_rd", rd_total - r0, 0);

        // Randomized traffic, including ranges that wrap the address space.
        lat_min = 2; lat_max = 6;
        pop_pct = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) pop_pct = (i / 500) % 3 == 0 ? 90 : ((i / 500) % 3 == 1 ? 10 : 50);
            if (i == 0 || $urandom_range(99) < 2) begin
                I_BASE_ADDR = ($urandom_range(3) == 0) ? AW'(28'hFFFFFFF - $urandom_range(5))
                                                        : AW'($urandom);
                I_LENGTH    = AW'($urandom_range(40));
                I_LOOP      = 1'($urandom_range(1));
                I_START     = 1'b1;
            end else begin
                I_START = 1'b0;
            end
            if ($urandom_range(199) == 0) I_LOOP = ~I_LOOP;
            I_POP = ($urandom_range(99) < pop_pct);
            tick();
        end
        I_START = 1'b0;
        I_POP   = 1'b0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
